activation_skew_feeder: RTL and testbench
=========================================

# activation_skew_feeder

Upstream feeder for the weight-proxy systolic array. It buffers a tile of DEPTH activation vectors, then streams them into the array's row delay chains with a diagonal skew: row r lags row r-1 by one cycle. It drives the chain's `shift_en` and honours the same `stall` that freezes the array, so the skew is never corrupted.

## Interface
Parameters:
- WORD_SIZE, 16, signed element width.
- NUM_ROWS, 4, array rows (lanes).
- DEPTH, 4, vectors per tile. Must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  load vector present.
- in_ready  out  1  feeder can accept a load vector.
- in_data  in  NUM_ROWS*WORD_SIZE  vector; lane r = bits [r*WORD_SIZE +: WORD_SIZE], signed.
- start  in  1  begin streaming the buffered tile.
- stall  in  1  freeze streaming (shared with array).
- out_data  out  NUM_ROWS*WORD_SIZE  skewed lanes to array rows, registered.
- out_valid  out  NUM_ROWS  per-row valid, registered.
- shift_en  out  1  high while streaming; drives row chains.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the last skewed word is emitted.

## Operation
- Storage: DEPTH×NUM_ROWS×WORD_SIZE register buffer, plus load counter `cnt` (0..DEPTH) and stream counter `t` (0..DEPTH+NUM_ROWS-2).
- **LOAD** (reset state):
  - in_ready = (cnt < DEPTH).
  - On in_valid && in_ready: buf[cnt] <= in_data; cnt++.
  - stall has no effect in LOAD.
  - start while cnt == DEPTH moves to STREAM with t = 0. start while cnt < DEPTH is ignored.
  - in_valid and start on the same edge with cnt == DEPTH-1: the load is taken and start is ignored.
- **STREAM**:
  - in_ready = 0; busy = 1; shift_en = 1.
  - On each non-stalled edge, for each row r: if 0 ≤ t-r < DEPTH then out lane r <= buf[t-r][r] and out_valid[r] <= 1; else out lane r <= 0 and out_valid[r] <= 0. Then t++.
  - The edge processing t = DEPTH+NUM_ROWS-2 goes to DONE.
  - stall = 1: t, out_data, out_valid and state are all held.
- **DONE**:
  - One cycle with done = 1 and busy = 0.
  - out_data and out_valid are cleared to 0. cnt <= 0.
  - Next state is LOAD.
- Data is passed unmodified, with no arithmetic. Sign is preserved bit-exactly.

## Timing
- Reset (async, immediate):
  - state = LOAD, cnt = 0, t = 0.
  - out_data = 0, out_valid = 0, shift_en = 0, busy = 0, done = 0.
  - in_ready = 1.
  - Buffer contents are don't-care.
- Reset asserted mid-STREAM aborts the tile. After release the feeder is in LOAD with cnt = 0, and the tile must be reloaded.
- Latency:
  - Load: accepted on the edge where in_valid && in_ready.
  - start sampled at edge k: shift_en and busy are high after edge k.
  - First output (row 0, vector 0) is registered at edge k+1.
  - Row r's first valid word is registered at edge k+1+r.
- STREAM occupies DEPTH+NUM_ROWS-1 non-stalled edges, plus one edge per stalled cycle.
- done is high in the cycle following the last STREAM edge. in_ready returns the cycle after done.
- Outputs are registered. in_ready, shift_en and busy are decoded from state only, with no combinational path from inputs.

## Test plan
All cases use WORD_SIZE=16, NUM_ROWS=4, DEPTH=4.
- Reset/idle: assert rst mid-cycle → all outputs 0 and in_ready = 1 immediately; start with an empty buffer → no state change.
- Basic tile: load vectors v[i][r] = 16·i + r, then pulse start → over 7 edges, out_valid = 0001, 0011, 0111, 1111, 1110, 1100, 1000; lane r at edge k+1+j = v[j][r]; done pulses once; in_ready = 1 one cycle later.
- Back-pressure: assert in_valid continuously through 6 vectors → only the first 4 accepted; in_ready = 0 after the 4th; vectors 5 and 6 are not stored.
- Stall: stall high for 3 cycles at t = 2 → out_data and out_valid frozen for exactly 3 cycles; total stream length is 10 edges; sequence otherwise identical to the basic tile.
- Simultaneous events: 4th in_valid and start on the same edge → load taken, start ignored; a later start streams normally. Signed values (0x8000, -1) pass through bit-exact.
- Reset mid-stream: assert rst at t = 3 → outputs 0 immediately, in_ready = 1 after release; a fresh tile then streams correctly.

Source files
------------

// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder: buffers a tile of DEPTH activation vectors and
// streams them into the array's row delay chains with a one-cycle-per-row
// diagonal skew. Streaming honours the array's shared stall.
module activation_skew_feeder #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_ROWS  = 4,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ROWS*WORD_SIZE-1:0] in_data,
  input  logic                          start,
  input  logic                          stall,
  output logic [NUM_ROWS*WORD_SIZE-1:0] out_data,
  output logic [NUM_ROWS-1:0]           out_valid,
  output logic                          shift_en,
  output logic                          busy,
  output logic                          done
);

  localparam int VW = NUM_ROWS * WORD_SIZE;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + NUM_ROWS);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(DEPTH + NUM_ROWS - 2);
  localparam logic [TW-1:0] T_DEPTH  = TW'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [VW-1:0]   out_data_q, out_data_d;
  logic [NUM_ROWS-1:0] out_valid_q, out_valid_d;
  logic [VW-1:0]   buf_q [DEPTH];
  logic [VW-1:0]   buf_d [DEPTH];
  logic [TW-1:0]   idx_s;

  // Next-state, buffer-write and skewed-lane selection for all three phases.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    t_d         = t_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    buf_d       = buf_q;
    idx_s       = '0;
    case (state_q)
      S_LOAD: begin
        // A load always wins over start; start only counts once the tile is full.
        if (in_valid && (cnt_q < CNT_FULL)) begin
          buf_d[cnt_q[AW-1:0]] = in_data;
          cnt_d                = cnt_q + CW'(1);
        end else if (start && (cnt_q == CNT_FULL)) begin
          state_d = S_STREAM;
          t_d     = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        if (!stall) begin
          // Row r sees vector t-r, so each row lags the one above by a cycle.
          for (int r = 0; r < NUM_ROWS; r++) begin
            if ((t_q >= TW'(r)) && ((t_q - TW'(r)) < T_DEPTH)) begin
              idx_s = t_q - TW'(r);
              out_data_d[r*WORD_SIZE +: WORD_SIZE] = buf_q[idx_s[AW-1:0]][r*WORD_SIZE +: WORD_SIZE];
              out_valid_d[r] = 1'b1;
            end else begin
              out_data_d[r*WORD_SIZE +: WORD_SIZE] = '0;
              out_valid_d[r] = 1'b0;
            end
          end
          if (t_q == T_LAST) begin
            state_d = S_DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        out_data_d  = '0;
        out_valid_d = '0;
        cnt_d       = '0;
        state_d     = S_LOAD;
      end
      default: begin
        state_d     = S_LOAD;
        cnt_d       = '0;
        t_d         = '0;
        out_data_d  = '0;
        out_valid_d = '0;
      end
    endcase
  end

  // Control and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Tile buffer; contents are meaningless until reloaded, so no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = (state_q == S_LOAD) && (cnt_q < CNT_FULL);
  assign busy      = (state_q == S_STREAM);
  assign shift_en  = (state_q == S_STREAM);
  assign done      = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Self-checking bench for activation_skew_feeder: a schedule-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_activation_skew_feeder;

  localparam int WS = 16;
  localparam int NR = 4;
  localparam int D  = 4;
  localparam int VW = WS * NR;
  localparam int NS = D + NR - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready;
  logic [VW-1:0] out_data;
  logic [NR-1:0] out_valid;
  logic          shift_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  activation_skew_feeder #(.WORD_SIZE(WS), .NUM_ROWS(NR), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .stall(stall), .out_data(out_data),
    .out_valid(out_valid), .shift_en(shift_en), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: phase + precomputed output schedule ----------------
  int            m_state = 0;  // 0 loading, 1 streaming, 2 finishing
  int            m_cnt = 0;
  int            m_slot = 0;
  logic [WS-1:0] m_vec  [D][NR];
  logic [NR-1:0] s_valid [NS];
  logic [WS-1:0] s_data  [NS][NR];
  logic [VW-1:0] e_data = '0;
  logic [NR-1:0] e_valid = '0;

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_cnt = 0; m_slot = 0; e_data = '0; e_valid = '0;
    end else if (m_state == 0) begin
      if (in_valid && m_cnt < D) begin
        for (int r = 0; r < NR; r++) m_vec[m_cnt][r] = in_data[r*WS +: WS];
        m_cnt++;
      end else if (start && m_cnt == D) begin
        for (int s = 0; s < NS; s++) begin
          s_valid[s] = '0;
          for (int r = 0; r < NR; r++) s_data[s][r] = '0;
        end
        // Vector j reaches row r on the (j+r)-th streaming step.
        for (int j = 0; j < D; j++)
          for (int r = 0; r < NR; r++) begin
            s_valid[j+r][r] = 1'b1;
            s_data[j+r][r]  = m_vec[j][r];
          end
        m_slot = 0;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (!stall) begin
        e_valid = s_valid[m_slot];
        for (int r = 0; r < NR; r++) e_data[r*WS +: WS] = s_data[m_slot][r];
        m_slot++;
        if (m_slot == NS) m_state = 2;
      end
    end else begin
      e_data = '0; e_valid = '0; m_cnt = 0; m_state = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_out_data", out_data, e_data);
      chk("m_out_valid", 64'(out_valid), 64'(e_valid));
      chk("m_in_ready", 64'(in_ready), 64'(m_state == 0 && m_cnt < D));
      chk("m_busy", 64'(busy), 64'(m_state == 1));
      chk("m_shift_en", 64'(shift_en), 64'(m_state == 1));
      chk("m_done", 64'(done), 64'(m_state == 2));
    end
  end

  // ---------------- directed helpers ----------------
  logic [NR-1:0] bv [7];

  function automatic logic [63:0] basic_word(input int j, input int base);
    logic [63:0] w;
    int k;
    w = '0;
    for (int r = 0; r < NR; r++) begin
      k = j - 1 - r;
      if (k >= 0 && k < D) w[r*WS +: WS] = 16'(base + 16*k + r);
    end
    return w;
  endfunction

  task automatic load_tile(input int base);
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      for (int r = 0; r < NR; r++) in_data[r*WS +: WS] = 16'(base + 16*i + r);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_basic(input int base);
    int dcount;
    dcount = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lit_busy_after_start", 64'(busy), 64'd1);
    chk("lit_first_valid_zero", 64'(out_valid), 64'd0);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk("lit_valid_seq", 64'(out_valid), 64'(bv[j-1]));
      chk("lit_data_seq", out_data, basic_word(j, base));
      if (done) dcount++;
    end
    chk("lit_done_last", 64'(done), 64'd1);
    @(negedge clk);
    chk("lit_done_once", 64'(dcount), 64'd1);
    chk("lit_done_drop", 64'(done), 64'd0);
    chk("lit_ready_back", 64'(in_ready), 64'd1);
    chk("lit_cleared", out_data, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [VW-1:0] sv [4];
  int busy_cnt;
  int done_cnt;

  initial begin
    bv[0] = 4'b0001; bv[1] = 4'b0011; bv[2] = 4'b0111; bv[3] = 4'b1111;
    bv[4] = 4'b1110; bv[5] = 4'b1100; bv[6] = 4'b1000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy | shift_en | done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Start with an empty buffer is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_start_busy", 64'(busy), 64'd0);
    chk("empty_start_ready", 64'(in_ready), 64'd1);

    // Basic tile
    load_tile(0);
    chk("full_ready_low", 64'(in_ready), 64'd0);
    run_basic(0);

    // Back-pressure: six vectors offered, four taken
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < NR; r++) in_data[r*WS +: WS] = 16'(256 + 16*i + r);
      @(negedge clk);
      if (i == 3) chk("bp_ready_after_4th", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    run_basic(256);

    // Stall for three cycles at t = 2
    load_tile(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (c >= 3 && c <= 5) begin
        chk("stall_frozen_valid", 64'(out_valid), 64'(4'b0011));
        chk("stall_frozen_data", out_data, basic_word(2, 0));
      end
      if (c == 6) chk("stall_resume_valid", 64'(out_valid), 64'(4'b0111));
      stall = (c >= 2 && c < 5);
      @(negedge clk);
    end
    chk("stall_stream_len", 64'(busy_cnt), 64'd10);
    chk("stall_done_once", 64'(done_cnt), 64'd1);

    // Simultaneous 4th load and start; signed pass-through
    sv[0] = {16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000};
    sv[1] = {16'h8001, 16'hFFFE, 16'h8000, 16'hFFFF};
    sv[2] = {16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
    sv[3] = {16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = sv[i];
      @(negedge clk);
    end
    in_data = sv[3]; start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    chk("sim_start_ignored", 64'(busy), 64'd0);
    chk("sim_load_taken", 64'(in_ready), 64'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) chk("sign_j1", out_data, 64'h0000_0000_0000_8000);
      if (j == 4) chk("sign_j4", out_data, 64'hFFFF_FFFE_FFFF_8000);
      if (j == 7) chk("sign_j7", out_data, 64'hFFFF_0000_0000_0000);
    end

    // Reset mid-stream at t = 3
    load_tile(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'(4'b0111));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_ctrl", 64'(busy | shift_en | done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    load_tile(32);
    run_basic(32);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
